alu_operand_arbiter: RTL

// - Shares the single 32-bit ALU operand path between two requesters (in0, in1)

---
 rtl/alu_pkg.sv | 13 +
 rtl/mux.sv | 13 +
 rtl/alu_operand_arbiter.sv | 122 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operand path.
package alu_pkg;

    typedef enum logic {
        ARB_EMPTY = 1'b0,
        ARB_FULL  = 1'b1
    } arb_state_t;

    localparam int   ALU_WIDTH = 32;
    localparam logic SRC0      = 1'b0;
    localparam logic SRC1      = 1'b1;

endpackage

// File: rtl/mux.sv
// Plain 2:1 data multiplexer; sel=0 passes in1, sel=1 passes in2.
module mux #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    assign out = sel ? in2 : in1;

endmodule

// File: rtl/alu_operand_arbiter.sv
// Two-source bounded-burst round-robin arbiter feeding a one-entry ALU operand register.
// state     | meaning
// ARB_EMPTY | output register holds no beat
// ARB_FULL  | output register holds a beat awaiting out_ready
module alu_operand_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH     = ALU_WIDTH,
    parameter int MAX_BURST = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    input  logic             out_ready
);

    localparam int             RUN_W   = $clog2(MAX_BURST + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_BURST);
    localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_last;
    logic [RUN_W-1:0] r_run;
    logic [WIDTH-1:0] r_data;
    logic             r_src;

    logic             w_load;
    logic             w_gnt_vld;
    logic             w_gnt;
    logic [WIDTH-1:0] w_mux_out;

    assign out_valid = (r_state == ARB_FULL);
    assign out_data  = r_data;
    assign out_src   = r_src;
    assign w_load    = !out_valid || out_ready;

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt     = SRC0;
        if (w_load) begin
            if (in0_valid && in1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt     = (r_run < RUN_MAX) ? r_last : ~r_last;
            end else if (in0_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt     = SRC0;
            end else if (in1_valid) begin
                w_gnt_vld = 1'b1;
                w_gnt     = SRC1;
            end
        end
    end

    // Readies are masked during reset so no upstream beat looks accepted while held in reset.
    assign in0_ready = rst_n && w_gnt_vld && (w_gnt == SRC0);
    assign in1_ready = rst_n && w_gnt_vld && (w_gnt == SRC1);

    mux #(
        .WIDTH (WIDTH)
    ) u_mux (
        .in1 (in0_data),
        .in2 (in1_data),
        .sel (w_gnt),
        .out (w_mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ARB_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_EMPTY: begin
                if (w_gnt_vld) w_state_nxt = ARB_FULL;
            end
            ARB_FULL: begin
                if (out_ready && !w_gnt_vld) w_state_nxt = ARB_EMPTY;
            end
            default: w_state_nxt = ARB_EMPTY;
        endcase
    end

    // last=1 with a saturated run makes the first contention after reset go to in0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last <= SRC1;
            r_run  <= RUN_MAX;
        end else if (w_gnt_vld) begin
            if (w_gnt == r_last) begin
                r_run <= (r_run >= RUN_MAX) ? RUN_MAX : r_run + RUN_ONE;
            end else begin
                r_last <= w_gnt;
                r_run  <= RUN_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_src  <= SRC0;
        end else if (w_gnt_vld) begin
            r_data <= w_mux_out;
            r_src  <= w_gnt;
        end
    end

endmodule
